// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
// Covers FSM encoding, requester IDs and the default burst-length width.
package axi_rd_arbiter_pkg;

  localparam int RA_LEN_W = 4;

  typedef enum logic [1:0] {
    RA_IDLE = 2'd0,
    RA_ADDR = 2'd1,
    RA_DATA = 2'd2
  } ra_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  localparam logic [3:0] RA_ID_IC = 4'd0;
  localparam logic [3:0] RA_ID_DC = 4'd1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin picker.
// Holds the owner of the most recently completed burst; a tie goes to the other side.
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_ic_i,
  input  logic   req_dc_i,
  input  logic   upd_i,
  input  owner_e upd_owner_i,
  output owner_e pick_o
);

  owner_e last_owner_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= OWN_IC;
    end else if (upd_i) begin
      last_owner_q <= upd_owner_i;
    end
  end

  always_comb begin
    if (req_ic_i && req_dc_i) begin
      pick_o = (last_owner_q == OWN_IC) ? OWN_DC : OWN_IC;
    end else if (req_dc_i) begin
      pick_o = OWN_DC;
    end else begin
      pick_o = OWN_IC;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Serialises I-side and D-side read bursts onto one AXI read channel.
// Routes beats to the burst owner and flags burst-length mismatches.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int LEN_W  = RA_LEN_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  input  logic [LEN_W-1:0]  ic_len,
  output logic              ic_gnt,
  output logic              ic_rvalid,
  output logic              ic_rlast,
  input  logic              dc_req,
  input  logic [31:0]       dc_addr,
  input  logic [LEN_W-1:0]  dc_len,
  output logic              dc_gnt,
  output logic              dc_rvalid,
  output logic              dc_rlast,
  output logic [DATA_W-1:0] rdata,
  output logic              arvalid,
  input  logic              arready,
  output logic [31:0]       araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [3:0]        arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rlast,
  output logic              len_err
);

  ra_state_e        state_q, state_d;
  owner_e           owner_q, owner_d, pick;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic             len_err_q, len_err_d;

  logic any_req, ar_hs, beat, last_beat;

  assign any_req   = ic_req | dc_req;
  assign ar_hs     = (state_q == RA_ADDR) && arready;
  assign beat      = (state_q == RA_DATA) && rvalid;
  assign last_beat = beat && rlast;

  rr_arb2 u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_ic_i    (ic_req),
    .req_dc_i    (dc_req),
    .upd_i       (last_beat),
    .upd_owner_i (owner_q),
    .pick_o      (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= RA_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RA_IDLE: if (any_req)   state_d = RA_ADDR;
      RA_ADDR: if (ar_hs)     state_d = RA_DATA;
      RA_DATA: if (last_beat) state_d = RA_IDLE;
      default:                state_d = RA_IDLE;
    endcase
  end

  always_comb begin
    arvalid   = (state_q == RA_ADDR);
    rready    = (state_q == RA_DATA);
    ic_gnt    = ar_hs && (owner_q == OWN_IC);
    dc_gnt    = ar_hs && (owner_q == OWN_DC);
    ic_rvalid = beat && (owner_q == OWN_IC);
    dc_rvalid = beat && (owner_q == OWN_DC);
    ic_rlast  = ic_rvalid && rlast;
    dc_rlast  = dc_rvalid && rlast;
    rdata     = rready ? rdata_i : '0;
  end

  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arid    = (owner_q == OWN_DC) ? RA_ID_DC : RA_ID_IC;
  assign len_err = len_err_q;

  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    owner_d   = owner_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    if ((state_q == RA_IDLE) && any_req) begin
      owner_d = pick;
      addr_d  = (pick == OWN_DC) ? dc_addr : ic_addr;
      len_d   = (pick == OWN_DC) ? dc_len  : ic_len;
    end
    if (ar_hs) cnt_d = '0;
    if (beat) begin
      cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
      // Error when rlast and "counter reached len" disagree on this beat.
      if (rlast != (cnt_q == {1'b0, len_q})) len_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OWN_IC;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares the single AXI read channel between the instruction-cache refill path and the data-cache refill/uncached-load path. It serialises one read burst at a time, routes returned beats only to the requester that owns the burst, and checks the burst length. The data side's response latency feeds `dcache_busy`, which stalls the MEM stage, so this block directly sets load-miss stall length.

## Interface
- `LEN_W`, 4: burst length field width; beats = len+1.
- `DATA_W`, 32: read data width.
- `clk` in 1: clock; sole clock domain.
- `reset` in 1: synchronous, active-high.
- `ic_req` in 1: I-side read request; held with addr/len until `ic_gnt`.
- `ic_addr` in 32: I-side start address.
- `ic_len` in LEN_W: I-side burst length minus 1.
- `ic_gnt` out 1: one-cycle pulse on the AR handshake of the I-side burst.
- `ic_rvalid` out 1: I-side data beat valid.
- `ic_rlast` out 1: I-side last beat.
- `dc_req`, `dc_addr`, `dc_len`, `dc_gnt`, `dc_rvalid`, `dc_rlast`: same meaning for the D-side.
- `rdata` out DATA_W: beat data, shared by both requesters; qualified by `*_rvalid`.
- `arvalid` out 1, `arready` in 1, `araddr` out 32, `arlen` out LEN_W, `arid` out 4: AXI read-address channel; `arid` is 0 for I-side, 1 for D-side.
- `rvalid` in 1, `rready` out 1, `rdata_i` in DATA_W, `rlast` in 1: AXI read-data channel.
- `len_err` out 1: sticky flag; set on a burst-length mismatch.

## Operation
- FSM has three states: IDLE, ADDR, DATA. Encoding is `RA_IDLE=2'd0`, `RA_ADDR=2'd1`, `RA_DATA=2'd2`.
- **IDLE:** if any request is pending, the arbiter selects an owner and latches owner, addr and len. Next state is ADDR.
- **Owner selection:**
  - Only one request pending: that requester wins.
  - Both pending: round-robin against `last_owner`, so the requester not served last wins.
  - `last_owner` resets to I, so D wins the first tie.
- **ADDR:**
  - `arvalid`=1, and `araddr`/`arlen`/`arid` come from the latched values.
  - On `arvalid && arready`: pulse the owner's `*_gnt`, clear the beat counter, go to DATA.
- **DATA:**
  - `rready`=1.
  - Each `rvalid` beat: `rdata`=`rdata_i`, and the owner's `*_rvalid`=`rvalid` (combinational pass-through). The non-owner's rvalid/rlast stay 0.
  - The beat counter increments per beat, with width LEN_W+1.
  - On `rvalid && rlast`: update `last_owner`, go to IDLE.
- **Length check:** `len_err` is set if either of these occurs:
  - `rlast` arrives with counter != latched len;
  - a beat arrives with counter == len and `rlast`=0. The FSM stays in DATA until `rlast` regardless.
- One burst is outstanding at a time; no interleaving.
- Requests that arrive during ADDR/DATA wait. They are evaluated in the first IDLE cycle after the burst.
- A requester dropping `*_req` before its grant is illegal. The arbiter ignores this once ownership is latched.

## Timing
- **Reset values:**
  - State IDLE.
  - `arvalid`, `rready`, `*_gnt`, `*_rvalid`, `*_rlast`, `len_err` all 0.
  - `araddr`=0, `arlen`=0, `arid`=0, `last_owner`=I.
- **Request to `arvalid`:** 1 cycle. The request is sampled at edge N in IDLE; `arvalid`=1 during cycle N+1.
- **Handshake to DATA:** `*_gnt` is high in the same cycle as the `arvalid&&arready` handshake; DATA starts the next cycle.
- **Data path:** zero-latency from `rvalid` to `*_rvalid`. A back-to-back beat every cycle is supported.
- **Burst to burst:** a minimum of one IDLE cycle between the `rlast` beat and the next `arvalid`.
- `arready` held low indefinitely: stay in ADDR with all AR outputs stable.
- `rvalid` arriving in IDLE/ADDR: ignored, since `rready`=0.
- Synchronous reset mid-burst: next edge forces IDLE and drops `arvalid`/`rready`. Bus-side cleanup belongs to the system reset.

## Structure
- Put FSM state encodings, requester IDs (`RA_ID_IC=4'd0`, `RA_ID_DC=4'd1`) and the default `LEN_W` in `global_defines.vh`.
- One sub-module, `rr_arb2`: a 2-requester round-robin picker holding `last_owner`.
- The FSM, address latch, beat counter and length checker live in `axi_rd_arbiter`.

## Test plan
- **Single I-side request:** `ic_req` with addr 0x1FC0_0000, len 7, `arready` high.
  - `arvalid` is high the cycle after the request, with `arid`=0 and `ic_gnt` pulsed once.
  - 8 beats are delivered on `ic_rvalid`, `ic_rlast` on beat 8, and `dc_rvalid` stays 0 throughout.
- **Simultaneous requests from reset:** `ic_req` and `dc_req` both asserted.
  - D is served first (`arid`=1, dc len 0, one beat).
  - Then I is served; `arvalid` for I rises exactly 2 cycles after the D `rlast` beat.
- **Continuous dual requests:** both requesters always pending, 4 bursts. The grant order is D, I, D, I.
- **`arready` stall:** `arready` held 0 for 10 cycles. `araddr`/`arlen` stay stable, no gnt pulses, then the grant fires on the first `arready`=1.
- **Length errors:**
  - len 3 but slave asserts `rlast` on beat 2: `len_err`=1 and stays set.
  - len 1 with no `rlast` on beat 2: `len_err`=1, and the FSM returns to IDLE only after `rlast`.
- **Mid-burst reset:** `reset` pulsed on beat 3 of 8. Next cycle: state IDLE, `rready`=0, all outputs at reset values. A new `dc_req` is then granted normally.
